// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and default timings
// for the LED-indicator and handshake use cases.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH   = 10;
    localparam int DEFAULT_HOLDOFF = 2;

    // LED indicators need a human-visible blink; handshakes want a short, clean level.
    localparam int LED_WIDTH       = 5_000_000;
    localparam int LED_HOLDOFF     = 1_000_000;
    localparam int HS_WIDTH        = 4;
    localparam int HS_HOLDOFF      = 0;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter with a zero flag; decrementing stops at zero.
module load_down_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle strobe into a WIDTH-cycle level followed by HOLDOFF dead time.
// Define PULSE_STRETCHER_RETRIGGER_EN to let strobes during the level restart it.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int HOLDOFF = DEFAULT_HOLDOFF,
    parameter int CW      = 16,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    input  logic          drop_clr,
    output logic          level,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] drop_cnt
);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam bit            HAS_HOLDOFF = (HOLDOFF > 0);
    localparam logic [CW-1:0] WIDTH_LOAD  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = HAS_HOLDOFF ? CW'(HOLDOFF - 1) : '0;

    state_t        state;
    logic          cnt_load;
    logic [CW-1:0] cnt_value;
    logic          cnt_dec;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          retrig_hit;
    logic          reject;

    assign retrig_hit = RETRIG && (state == ST_ACTIVE) && pulse_in;
    assign reject     = pulse_in && !retrig_hit &&
                        ((state == ST_ACTIVE) || (state == ST_HOLDOFF));

    // One counter serves both phases: reloaded with the phase length minus one.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = WIDTH_LOAD;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load = pulse_in;
            end
            ST_ACTIVE: begin
                if (retrig_hit) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = HOLD_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                cnt_dec = !cnt_zero;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    load_down_counter #(
        .CW(CW)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(cnt_value),
        .dec       (cnt_dec),
        .count     (cnt),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            level    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state <= ST_ACTIVE;
                        level <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!retrig_hit && cnt_zero) begin
                        level <= 1'b0;
                        done  <= 1'b1;
                        if (HAS_HOLDOFF) begin
                            state <= ST_HOLDOFF;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Clear wins over a same-cycle rejection; the count sticks at all-ones.
            if (drop_clr) begin
                drop_cnt <= '0;
            end else if (reject && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DW'(1);
            end
        end
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a single-cycle strobe, such as the one-shot output of the rising-edge detector, back into a timed level.
- Each accepted strobe drives `level` high for exactly WIDTH clocks, then enforces a HOLDOFF dead time.
- Strobes that cannot be accepted are counted as dropped.
- Sits between edge-detect/debounce front ends and slow consumers: LED indicators, enables, handshakes into other clock-agnostic logic.

Parameters:
- WIDTH, 10, cycles `level` stays high per accepted strobe; legal range 1..2^CW-1.
- HOLDOFF, 2, dead-time cycles after `level` falls before a new strobe is accepted; 0 allowed.
- CW, 16, width of the internal cycle counter.
- DW, 8, width of the dropped-strobe counter.

Ports:
- clk  input  1  on-board clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low: asserted when 0; clears all state immediately; deassertion is synchronous to clk upstream.
- pulse_in  input  1  strobe, normally one cycle wide; a multi-cycle high is treated as one strobe per high cycle.
- drop_clr  input  1  synchronous clear of drop_cnt.
- level  output  1  stretched output, registered.
- busy  output  1  high in ACTIVE or HOLDOFF, registered.
- done  output  1  one-cycle pulse on the first clock `level` is low after an ACTIVE period.
- drop_cnt  output  DW  saturating count of rejected strobes.

Behaviour:
- Reset (rst=0):
  - State goes to IDLE, counter to 0.
  - level=0, busy=0, done=0, drop_cnt=0.
  - Reset mid-ACTIVE drops `level` asynchronously; no `done` is produced.
- States: IDLE, ACTIVE, HOLDOFF (2-bit encoding).
- IDLE:
  - pulse_in=1 at edge N gives state ACTIVE, counter=WIDTH-1, level=1 and busy=1 visible after edge N. Latency is one clock.
- ACTIVE:
  - Counter decrements each clock.
  - When counter==0 at an edge, level goes to 0 and done goes to 1 for that one cycle.
  - Next state is HOLDOFF with counter=HOLDOFF-1 if HOLDOFF>0; otherwise IDLE with busy=0.
  - `level` is therefore high for exactly WIDTH consecutive clocks.
- HOLDOFF:
  - Counter decrements each clock.
  - When counter==0, state goes to IDLE and busy goes to 0.
- Strobe acceptance (without the optional feature):
  - A strobe is accepted only in IDLE.
  - A strobe arriving in ACTIVE or HOLDOFF, including the exact terminal cycle of either, is rejected and increments drop_cnt.
  - With HOLDOFF=0, the minimum strobe-to-strobe acceptance spacing is WIDTH+1 clocks.
- drop_cnt:
  - Increments by 1 per rejected cycle.
  - Saturates at 2^DW-1; never wraps.
  - drop_clr has priority over a simultaneous increment: the result is 0.
- done is never asserted coincident with level=1.
- pulse_in is assumed already synchronous to clk; no synchronizer inside.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined:
  - A strobe in ACTIVE reloads counter=WIDTH-1; level stays continuously high; it is not counted as dropped.
  - A strobe on the ACTIVE terminal cycle also reloads; no `done` is produced, and `done` is emitted only when the final period expires.
  - Strobes in HOLDOFF are still dropped.
- Undefined: behaviour exactly as in Behaviour (non-retriggerable monostable).

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_HOLDOFF=2'd2.
  - Default WIDTH/HOLDOFF values for LED and handshake uses.
- One natural sub-module: `load_down_counter` (CW-bit, synchronous load, decrement enable, zero flag).
  - Shared by the ACTIVE and HOLDOFF phases.
  - Reusable in the debouncer.
- The saturating drop counter stays inline.

Test Plan:
- Reset/idle: rst=0 for 3 clocks, then release → level=0, busy=0, done=0, drop_cnt=0; no output change without pulse_in.
- Single strobe (WIDTH=10, HOLDOFF=2):
  - pulse_in high one cycle at edge 5 → level high edges 6..15 inclusive (10 clocks).
  - done=1 during cycle after edge 15.
  - busy high through edge 17.
- Dropped strobes:
  - Strobes at offsets +3 (ACTIVE) and +11 (HOLDOFF) after an accepted one → drop_cnt=2; level width still 10.
  - Next strobe at +13 accepted.
- Saturation/clear (DW=2):
  - 5 rejected strobes → drop_cnt=3.
  - drop_clr coincident with a rejected strobe → drop_cnt=0.
- Async reset mid-ACTIVE: rst=0 asserted between edges at count 4 → level falls without waiting for a clock edge; done never asserts; after release, IDLE accepts a new strobe.
- Retrigger (macro defined): strobes at +0, +7, +14 → level high continuously for 24 clocks; single done; drop_cnt=0. Same stimulus with macro undefined → two 10-clock periods, drop_cnt=1.
